// File: rtl/pipelined_adder.sv
// Pipelined WIDTH-bit adder: STAGES ripple chunks with a registered carry between chunks,
// valid/ready on both sides. Define ADD_SUB_EN to add the sub port (a - b via a + ~b + 1).
module pipelined_adder #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
`ifdef ADD_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out
);

  localparam int CHUNK = WIDTH / STAGES;

  logic             stall_s;
  logic [WIDTH-1:0] b_in_s;
  logic             c_in_s;

  logic             valid_r [STAGES];
  logic             carry_r [STAGES];
  logic [WIDTH-1:0] a_r     [STAGES];
  logic [WIDTH-1:0] b_r     [STAGES];
  logic [WIDTH-1:0] s_r     [STAGES];

  // A held result blocks the whole pipe, bubbles included.
  assign stall_s  = valid_r[STAGES-1] & ~out_ready;
  assign in_ready = ~stall_s;

  // Operand conditioning at entry; subtraction folds into the add as a + ~b + 1.
  always_comb begin
`ifdef ADD_SUB_EN
    if (sub) begin
      b_in_s = ~b;
      c_in_s = 1'b1;
    end else begin
      b_in_s = b;
      c_in_s = carry_in;
    end
`else
    b_in_s = b;
    c_in_s = carry_in;
`endif
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [WIDTH-1:0] a_prev_s;
    logic [WIDTH-1:0] b_prev_s;
    logic [WIDTH-1:0] s_prev_s;
    logic [WIDTH-1:0] s_next_s;
    logic             c_prev_s;
    logic             v_prev_s;
    logic [CHUNK:0]   chunk_s;

    if (k == 0) begin : g_head
      assign a_prev_s = a;
      assign b_prev_s = b_in_s;
      assign s_prev_s = {WIDTH{1'b0}};
      assign c_prev_s = c_in_s;
      assign v_prev_s = in_valid & in_ready;
    end else begin : g_body
      assign a_prev_s = a_r[k-1];
      assign b_prev_s = b_r[k-1];
      assign s_prev_s = s_r[k-1];
      assign c_prev_s = carry_r[k-1];
      assign v_prev_s = valid_r[k-1];
    end

    assign chunk_s = {1'b0, a_prev_s[k*CHUNK +: CHUNK]}
                   + {1'b0, b_prev_s[k*CHUNK +: CHUNK]}
                   + {{CHUNK{1'b0}}, c_prev_s};

    // Merge this stage's chunk into the partial sum carried down the pipe.
    always_comb begin
      s_next_s                     = s_prev_s;
      s_next_s[k*CHUNK +: CHUNK]   = chunk_s[CHUNK-1:0];
    end

    // Stage register: shifts when the pipe is not stalled, holds otherwise.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        valid_r[k] <= 1'b0;
        carry_r[k] <= 1'b0;
        a_r[k]     <= {WIDTH{1'b0}};
        b_r[k]     <= {WIDTH{1'b0}};
        s_r[k]     <= {WIDTH{1'b0}};
      end else if (!stall_s) begin
        valid_r[k] <= v_prev_s;
        carry_r[k] <= chunk_s[CHUNK];
        a_r[k]     <= a_prev_s;
        b_r[k]     <= b_prev_s;
        s_r[k]     <= s_next_s;
      end
    end
  end

  assign out_valid = valid_r[STAGES-1];
  assign sum       = s_r[STAGES-1];
  assign carry_out = carry_r[STAGES-1];

endmodule

// File: doc/pipelined_adder.md
Name: pipelined_adder

Overview:
- Parametrised, pipelined successor to the fixed 8-bit ripple adder used in the MAC datapath.
- Splits a WIDTH-bit add into STAGES equal ripple chunks, with the carry registered between chunks, so the adder closes timing at wider accumulator widths.
- Valid/ready handshake on both sides.
- Upstream is the multiplier/partial-product path; downstream is the accumulator register.

Parameters:
- WIDTH, 16, operand and sum width in bits.
- STAGES, 4, number of pipeline stages. Legal range 1..WIDTH; WIDTH % STAGES must be 0.
- CHUNK, WIDTH/STAGES, derived local width per stage. Not user-overridable.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operands a, b and carry_in are valid.
- in_ready  output  1  block accepts operands this cycle.
- a  input  WIDTH  operand A, unsigned.
- b  input  WIDTH  operand B, unsigned.
- carry_in  input  1  carry into bit 0.
- out_valid  output  1  sum and carry_out are valid.
- out_ready  input  1  downstream accepts the result.
- sum  output  WIDTH  result bits [WIDTH-1:0] of a+b+carry_in.
- carry_out  output  1  carry out of bit WIDTH-1.

Behaviour:
- Reset: the clock is single; rst is asynchronous and active-high.
  - Clears every stage valid bit, all stage data/carry registers, sum (0), carry_out (0) and out_valid (0).
  - in_ready is 1 while rst is low and the pipe is empty.
  - Reset mid-operation discards all in-flight transactions; none appear after reset release.
- Stage k (k = 0..STAGES-1):
  - Adds chunk k of a and b plus the carry from stage k-1 (carry_in for k=0).
  - Stores the CHUNK result bits and the chunk carry.
  - Forwards the not-yet-added upper chunks of a/b and the lower sum chunks already computed (skew registers).
- Last-stage registers drive sum/carry_out directly; no combinational path from inputs to outputs.
- Accept: a transaction is accepted at a rising edge where in_valid && in_ready.
- Latency: accepted at edge N, out_valid is high after edge N+STAGES-1. STAGES=1 gives a registered adder whose result is valid after the accepting edge.
- Stall: stall = out_valid && !out_ready.
  - On stall, all stage registers hold, including bubbles; there is no bubble collapse.
  - in_ready = !stall, combinational from out_valid/out_ready only; it does not depend on in_valid.
- Advance: when !stall, every stage shifts one position per edge. The stage-0 valid bit loads in_valid && in_ready.
- Throughput: one result per cycle with out_ready held 1. Results emerge strictly in acceptance order.
- Simultaneous events: an output consumed and an input accepted on the same edge are both legal and lose no data.
- Stability: while out_valid && !out_ready, sum and carry_out hold stable.
- Width rule: {carry_out, sum} == a + b + carry_in computed at WIDTH+1 bits. No truncation or saturation.

Optional Feature:
- Macro: ADD_SUB_EN.
- Defined:
  - Adds port sub (input, 1), captured with the operands and carried alongside them.
  - sub=1 computes a + ~b + 1; carry_in is ignored, and carry_out=1 means no borrow (a >= b).
  - sub=0 behaves exactly as the add path.
- Undefined: the sub port is absent and the block is a pure adder.

Test Plan (WIDTH=16, STAGES=4):
- Reset: assert rst mid-stream with 3 transactions in flight -> out_valid=0, sum=0x0000, carry_out=0 immediately; no result appears for 8 cycles after release.
- Single add, cross-chunk carry: a=0x00FF, b=0x0001, carry_in=0, accepted at edge 0 -> out_valid=1 after edge 3, sum=0x0100, carry_out=0.
- Full ripple and carry_in: a=0xFFFF, b=0x0000, carry_in=1 -> sum=0x0000, carry_out=1. Also a=0x8000, b=0x8000, carry_in=0 -> sum=0x0000, carry_out=1.
- Streaming: four back-to-back adds (0x0001+0x0001, 0x1234+0x1111, 0x0F0F+0x00F1, 0xFFFE+0x0001) with out_ready=1 -> results 0x0002, 0x2345, 0x1000, 0xFFFF on four consecutive cycles, carry_out all 0.
- Backpressure: pipe full, out_ready=0 for 3 cycles -> in_ready=0, sum/carry_out stable, then drained in order with no loss or duplication.
- ADD_SUB_EN: sub=1, a=0x0005, b=0x0007 -> sum=0xFFFE, carry_out=0. sub=1, a=0x0007, b=0x0005 -> sum=0x0002, carry_out=1.
